// File: rtl/approx_mac_pkg.sv
// approx_mac_pkg: shared state encoding and default widths for the product accumulator
package approx_mac_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
   localparam int PROD_W = 8;
   localparam int ACC_W_DEF = 16;
   localparam int MAX_LEN_DEF = 16;
endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: accumulator adder with carry out; ACC_SATURATE_EN clamps to all-ones on carry, otherwise wraps
module mac_sat_add import approx_mac_pkg::*; #(
   parameter int W = ACC_W_DEF
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         carry_o
);
   logic [W:0] raw;
   assign raw = {1'b0, a_i} + {1'b0, b_i};
   assign carry_o = raw[W];
`ifdef ACC_SATURATE_EN
   assign sum_o = raw[W] ? {W{1'b1}} : raw[W-1:0];
`else
   assign sum_o = raw[W-1:0];
`endif
endmodule

// File: rtl/approx_mac_accum.sv
// approx_mac_accum: accumulates one frame of 8-bit products into a held result; ACC_SATURATE_EN selects clamp instead of wrap
module approx_mac_accum import approx_mac_pkg::*; #(
   parameter int ACC_W = ACC_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);
   state_e state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d, add_sum, prod_ext, sum_q;
   logic [CNT_W-1:0] cnt_q, cnt_d, count_q;
   logic ovf_q, ovf_d, res_ovf_q, carry, beat, open, close;

   assign prod_ext = {{(ACC_W - PROD_W){1'b0}}, in_prod};
   assign in_ready = (state_q != DONE) | out_ready;
   assign beat = in_valid & in_ready;
   assign open = state_q == ACCUM;
   assign out_valid = state_q == DONE;
   assign out_sum = sum_q;
   assign out_count = count_q;
   assign out_ovf = res_ovf_q;

   mac_sat_add #(.W(ACC_W)) u_add (
      .a_i(acc_q),
      .b_i(prod_ext),
      .sum_o(add_sum),
      .carry_o(carry)
   );

   // an open frame extends on each beat, otherwise the beat starts a fresh frame
   always_comb begin
      acc_d = open ? add_sum : prod_ext;
      cnt_d = open ? cnt_q + CNT_W'(1) : CNT_W'(1);
      ovf_d = open & (ovf_q | carry);
      close = in_last | (cnt_d == CNT_W'(MAX_LEN));
      state_d = beat ? (close ? DONE : ACCUM) : ((state_q == DONE) && out_ready) ? IDLE : state_q;
   end

   // frame state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;

   // running accumulator plus the result held for the consumer
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         sum_q <= '0;
         count_q <= '0;
         res_ovf_q <= 1'b0;
      end else if (beat) begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         if (close) begin
            sum_q <= acc_d;
            count_q <= cnt_d;
            res_ovf_q <= ovf_d;
         end
      end
endmodule

// File: tb/tb_approx_mac_accum.sv
// tb_approx_mac_accum: vector table, hand sequences and a random scoreboard run for approx_mac_accum
module tb_approx_mac_accum;
   typedef struct packed {logic [15:0] sum; logic [4:0] cnt; logic ovf;} res_t;
   typedef struct packed {logic [31:0] p; logic [2:0] n; logic [15:0] sum;} vec_t;

   logic clk = 0, rst_n = 1;
   logic in_valid = 0, in_last = 0, out_ready = 0;
   logic [7:0] in_prod = 0;
   logic in_ready, out_valid, out_ovf;
   logic [15:0] out_sum;
   logic [4:0] out_count;

   logic b_valid = 0, b_last = 0;
   logic [7:0] b_prod = 0;
   logic b_in_ready, b_out_valid, b_ovf;
   logic [7:0] b_sum;
   logic [4:0] b_count;

   int checks = 0, errors = 0;
   res_t exp_q[$];
   bit rand_ready = 0;
   logic force_ready = 1;
   int m_sum = 0, m_cnt = 0;
   bit m_ovf = 0, m_open = 0;
   bit hold = 0;
   res_t held;

   approx_mac_accum dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_count(out_count), .out_ovf(out_ovf)
   );

   approx_mac_accum #(.ACC_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_in_ready), .in_prod(b_prod),
      .in_last(b_last), .out_valid(b_out_valid), .out_ready(1'b1), .out_sum(b_sum),
      .out_count(b_count), .out_ovf(b_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : force_ready;
   end

   always @(negedge clk) begin : monitor
      res_t e;
      if (!rst_n) hold = 0;
      else begin
         if (hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", {out_sum, out_count, out_ovf}, held);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got sum %0d count %0d with no frame outstanding", out_sum, out_count);
            end else begin
               e = exp_q.pop_front();
               check("sb_sum", out_sum, e.sum);
               check("sb_count", out_count, e.cnt);
               check("sb_ovf", out_ovf, e.ovf);
            end
         end
         hold = out_valid && !out_ready;
         held = {out_sum, out_count, out_ovf};
      end
   end

   task automatic beat(input logic [7:0] p, input logic l, input int gap, output int waited);
      bit ok = 0;
      waited = 0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1; in_prod = p; in_last = l;
      while (!ok && waited < 64) begin
         @(negedge clk);
         if (in_ready) ok = 1;
         else begin @(posedge clk); #1; waited++; end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL beat_accept_timeout: got no in_ready in %0d cycles expected acceptance", waited);
      end else begin
         if (!m_open) begin m_sum = 0; m_cnt = 0; m_ovf = 0; m_open = 1; end
         m_sum += p;
         m_cnt++;
         if (m_sum > 65535) begin m_ovf = 1; m_sum -= 65536; end
         if (l || m_cnt == 16) begin
            exp_q.push_back({16'(m_sum), 5'(m_cnt), m_ovf});
            m_open = 0;
         end
         @(posedge clk); #1;
      end
      in_valid = 0; in_last = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   task automatic b_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2, input int n);
      logic [23:0] ps;
      ps = {p0, p1, p2};
      for (int j = 0; j < n; j++) begin
         b_valid = 1; b_prod = ps[23 - 8*j -: 8]; b_last = (j == n - 1);
         @(posedge clk); #1;
      end
      b_valid = 0; b_last = 0;
   endtask

   initial begin
      vec_t vt[5];
      logic [31:0] pv;
      int w, len;
      bit auto_close;
      logic [7:0] exp8;
      vt[0] = '{p: 32'h0A141E28, n: 3'd4, sum: 16'd100};
      vt[1] = '{p: 32'hFFFFFFFF, n: 3'd4, sum: 16'd1020};
      vt[2] = '{p: 32'h00000000, n: 3'd1, sum: 16'd0};
      vt[3] = '{p: 32'h01020300, n: 3'd3, sum: 16'd6};
      vt[4] = '{p: 32'h80400000, n: 3'd2, sum: 16'd192};

      #2 rst_n = 0;
      #10;
      check("rst_valid", out_valid, 0);
      check("rst_sum", out_sum, 0);
      check("rst_count", out_count, 0);
      check("rst_ovf", out_ovf, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      check("post_rst_in_ready", in_ready, 1);

      for (int i = 0; i < 5; i++) begin
         pv = vt[i].p;
         for (int j = 0; j < int'(vt[i].n); j++) beat(pv[31 - 8*j -: 8], j == int'(vt[i].n) - 1, 0, w);
         check("vec_valid", out_valid, 1);
         check("vec_sum", out_sum, vt[i].sum);
         check("vec_count", out_count, vt[i].n);
         check("vec_ovf", out_ovf, 0);
         @(posedge clk); #1;
         check("vec_valid_one_cycle", out_valid, 0);
      end

      for (int j = 0; j < 3; j++) beat(8'd7, 1'b0, 0, w);
      rst_n = 0;
      #3;
      check("midrst_valid", out_valid, 0);
      check("midrst_sum", out_sum, 0);
      check("midrst_count", out_count, 0);
      check("midrst_in_ready", in_ready, 1);
      m_open = 0;
      exp_q.delete();
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      beat(8'd5, 1'b0, 0, w);
      beat(8'd6, 1'b1, 0, w);
      check("midrst_next_sum", out_sum, 11);
      check("midrst_next_count", out_count, 2);
      @(posedge clk); #1;

      @(negedge clk) force_ready = 0;
      @(posedge clk); #1;
      beat(8'd225, 1'b1, 0, w);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_sum", out_sum, 225);
      end
      force_ready = 1;
      @(posedge clk); #1;
      beat(8'd7, 1'b1, 0, w);
      check("bp_same_cycle_accept", w, 0);
      check("bp_new_valid", out_valid, 1);
      check("bp_new_sum", out_sum, 7);
      @(posedge clk); #1;

      for (int j = 0; j < 16; j++) beat(8'd1, 1'b0, 0, w);
      check("auto_valid", out_valid, 1);
      check("auto_count", out_count, 16);
      check("auto_sum", out_sum, 16);
      beat(8'd3, 1'b1, 0, w);
      check("auto_next_count", out_count, 1);
      check("auto_next_sum", out_sum, 3);
      @(posedge clk); #1;

`ifdef ACC_SATURATE_EN
      exp8 = 8'd255;
`else
      exp8 = 8'd44;
`endif
      check("ovf_in_ready", b_in_ready, 1);
      b_frame(8'd200, 8'd100, 8'd0, 2);
      check("ovf_valid", b_out_valid, 1);
      check("ovf_sum", b_sum, exp8);
      check("ovf_count", b_count, 2);
      check("ovf_flag", b_ovf, 1);
      b_frame(8'd1, 8'd2, 8'd0, 2);
      check("ovf_clear_sum", b_sum, 3);
      check("ovf_clear_flag", b_ovf, 0);
`ifdef ACC_SATURATE_EN
      exp8 = 8'd255;
`else
      exp8 = 8'd0;
`endif
      b_frame(8'd255, 8'd0, 8'd1, 3);
      check("ovf_late_sum", b_sum, exp8);
      check("ovf_late_flag", b_ovf, 1);

      rand_ready = 1;
      for (int f = 0; f < 1000; f++) begin
         len = $urandom_range(1, 16);
         auto_close = (len == 16) && ($urandom_range(0, 1) == 1);
         for (int j = 0; j < len; j++)
            beat(8'($urandom_range(0, 255)), (j == len - 1) && !auto_close, $urandom_range(0, 2), w);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
